// File: rtl/sbp_upd_sched.sv
// Update scheduler for a pipelined search tree: merges a lookup stream with
// queued table updates, bounding lookup runs so pending updates make progress.
module sbp_upd_sched #(
  parameter int STAGE_ID_BITS  = 6,
  parameter int LOCATION_BITS  = 11,
  parameter int NUM_STAGES     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int MAX_LOOKUP_RUN = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             lk_valid_i,
  input  logic [31:0]                      lk_ip_addr_i,
  output logic                             lk_ready_o,
  input  logic                             upd_valid_i,
  output logic                             upd_ready_o,
  input  logic [31:0]                      upd_ip_addr_i,
  input  logic [5:0]                       upd_length_i,
  input  logic [STAGE_ID_BITS-1:0]         upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0]         upd_location_i,
  input  logic [STAGE_ID_BITS-1:0]         upd_childs_stage_id_i,
  input  logic [LOCATION_BITS-1:0]         upd_childs_location_i,
  input  logic [1:0]                       upd_childs_lr_i,
  output logic                             lookup_o,
  output logic [31:0]                      ip_addr_o,
  output logic                             upd_o,
  output logic [5:0]                       upd_length_o,
  output logic [STAGE_ID_BITS-1:0]         upd_stage_id_o,
  output logic [LOCATION_BITS-1:0]         upd_location_o,
  output logic [STAGE_ID_BITS-1:0]         upd_childs_stage_id_o,
  output logic [LOCATION_BITS-1:0]         upd_childs_location_o,
  output logic [1:0]                       upd_childs_lr_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             upd_idle_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int RC_W  = $clog2(MAX_LOOKUP_RUN+1);
  localparam int ENT_W = 32 + 6 + 2*STAGE_ID_BITS + 2*LOCATION_BITS + 2;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_LOOKUP_RUN);
  localparam logic [RC_W-1:0]  RC_ZERO  = {RC_W{1'b0}};
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [NUM_STAGES:0] SH_ZERO = {(NUM_STAGES+1){1'b0}};

  logic [ENT_W-1:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [LVL_W-1:0]         count_r;
  logic [RC_W-1:0]          rc_r;
  logic [NUM_STAGES:0]      sh_r;

  logic                     nonempty_s;
  logic                     full_s;
  logic                     lk_ready_s;
  logic                     upd_ready_s;
  logic                     issue_lk_s;
  logic                     issue_upd_s;
  logic                     push_s;
  logic [RC_W-1:0]          rc_nxt_s;
  logic [LVL_W-1:0]         count_nxt_s;
  logic [ENT_W-1:0]         push_ent_s;
  logic [31:0]              h_ip_s;
  logic [5:0]               h_len_s;
  logic [STAGE_ID_BITS-1:0] h_stage_s;
  logic [LOCATION_BITS-1:0] h_loc_s;
  logic [STAGE_ID_BITS-1:0] h_cstage_s;
  logic [LOCATION_BITS-1:0] h_cloc_s;
  logic [1:0]               h_lr_s;

  // Issue arbitration: lookups win unless a pending update has waited a full run.
  always_comb begin
    nonempty_s  = (count_r != LVL_ZERO);
    full_s      = (count_r == LVL_FULL);
    lk_ready_s  = rst & ~(nonempty_s & (rc_r == RC_MAX));
    upd_ready_s = rst & ~full_s;
    issue_lk_s  = lk_valid_i & lk_ready_s;
    issue_upd_s = rst & ~issue_lk_s & nonempty_s;
    push_s      = upd_valid_i & upd_ready_s;

    if (issue_lk_s) begin
      if (!nonempty_s) begin
        rc_nxt_s = RC_ZERO;
      end else if (rc_r == RC_MAX) begin
        rc_nxt_s = RC_MAX;
      end else begin
        rc_nxt_s = rc_r + RC_ONE;
      end
    end else if (issue_upd_s) begin
      rc_nxt_s = RC_ZERO;
    end else begin
      rc_nxt_s = rc_r;
    end

    case ({push_s, issue_upd_s})
      2'b10:   count_nxt_s = count_r + LVL_ONE;
      2'b01:   count_nxt_s = count_r - LVL_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Entry packing and head-of-queue field extraction.
  always_comb begin
    push_ent_s = {upd_ip_addr_i, upd_length_i, upd_stage_id_i, upd_location_i,
                  upd_childs_stage_id_i, upd_childs_location_i, upd_childs_lr_i};
    {h_ip_s, h_len_s, h_stage_s, h_loc_s, h_cstage_s, h_cloc_s, h_lr_s} = mem_r[rd_ptr_r];
  end

  // Queue storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_ent_s;
    end
  end

  // Queue pointers, run counter, in-flight tracker and registered pipeline outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r              <= PTR_ZERO;
      rd_ptr_r              <= PTR_ZERO;
      count_r               <= LVL_ZERO;
      rc_r                  <= RC_ZERO;
      sh_r                  <= SH_ZERO;
      lookup_o              <= 1'b0;
      upd_o                 <= 1'b0;
      ip_addr_o             <= 32'h0000_0000;
      upd_length_o          <= 6'd0;
      upd_stage_id_o        <= {STAGE_ID_BITS{1'b0}};
      upd_location_o        <= {LOCATION_BITS{1'b0}};
      upd_childs_stage_id_o <= {STAGE_ID_BITS{1'b0}};
      upd_childs_location_o <= {LOCATION_BITS{1'b0}};
      upd_childs_lr_o       <= 2'b00;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (issue_upd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r  <= count_nxt_s;
      rc_r     <= rc_nxt_s;
      sh_r     <= {sh_r[NUM_STAGES-1:0], upd_o};
      lookup_o <= issue_lk_s;
      upd_o    <= issue_upd_s;
      if (issue_lk_s) begin
        ip_addr_o <= lk_ip_addr_i;
      end else if (issue_upd_s) begin
        ip_addr_o <= h_ip_s;
      end else begin
        ip_addr_o <= 32'h0000_0000;
      end
      if (issue_upd_s) begin
        upd_length_o          <= h_len_s;
        upd_stage_id_o        <= h_stage_s;
        upd_location_o        <= h_loc_s;
        upd_childs_stage_id_o <= h_cstage_s;
        upd_childs_location_o <= h_cloc_s;
        upd_childs_lr_o       <= h_lr_s;
      end else begin
        upd_length_o          <= 6'd0;
        upd_stage_id_o        <= {STAGE_ID_BITS{1'b0}};
        upd_location_o        <= {LOCATION_BITS{1'b0}};
        upd_childs_stage_id_o <= {STAGE_ID_BITS{1'b0}};
        upd_childs_location_o <= {LOCATION_BITS{1'b0}};
        upd_childs_lr_o       <= 2'b00;
      end
    end
  end

  assign lk_ready_o   = lk_ready_s;
  assign upd_ready_o  = upd_ready_s;
  assign fifo_level_o = count_r;
  // Derived purely from flops, so it carries no combinational input path.
  assign upd_idle_o   = (count_r == LVL_ZERO) && (sh_r == SH_ZERO) && !upd_o;

endmodule

// File: tb/tb_sbp_upd_sched.sv
// Self-checking bench for sbp_upd_sched: directed scenarios plus random traffic
// scored against a queue-based behavioural model.
module tb_sbp_upd_sched;

  localparam int SB    = 6;
  localparam int LB    = 11;
  localparam int NST   = 32;
  localparam int DEPTH = 8;
  localparam int MAXR  = 16;

  typedef struct packed {
    logic [31:0] ip;
    logic [5:0]  len;
    logic [SB-1:0] st;
    logic [LB-1:0] loc;
    logic [SB-1:0] cst;
    logic [LB-1:0] cloc;
    logic [1:0]  lr;
  } upd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_ip = 32'h0;
  logic        upd_valid = 1'b0;
  upd_t        u_in = '0;

  logic        lk_ready_o, upd_ready_o, lookup_o, upd_o, upd_idle_o;
  logic [31:0] ip_addr_o;
  logic [5:0]  upd_length_o;
  logic [SB-1:0] upd_stage_id_o, upd_childs_stage_id_o;
  logic [LB-1:0] upd_location_o, upd_childs_location_o;
  logic [1:0]  upd_childs_lr_o;
  logic [$clog2(DEPTH+1)-1:0] fifo_level_o;

  sbp_upd_sched #(
    .STAGE_ID_BITS(SB), .LOCATION_BITS(LB), .NUM_STAGES(NST),
    .FIFO_DEPTH(DEPTH), .MAX_LOOKUP_RUN(MAXR)
  ) dut (
    .clk(clk), .rst(rst),
    .lk_valid_i(lk_valid), .lk_ip_addr_i(lk_ip), .lk_ready_o(lk_ready_o),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready_o),
    .upd_ip_addr_i(u_in.ip), .upd_length_i(u_in.len),
    .upd_stage_id_i(u_in.st), .upd_location_i(u_in.loc),
    .upd_childs_stage_id_i(u_in.cst), .upd_childs_location_i(u_in.cloc),
    .upd_childs_lr_i(u_in.lr),
    .lookup_o(lookup_o), .ip_addr_o(ip_addr_o), .upd_o(upd_o),
    .upd_length_o(upd_length_o), .upd_stage_id_o(upd_stage_id_o),
    .upd_location_o(upd_location_o), .upd_childs_stage_id_o(upd_childs_stage_id_o),
    .upd_childs_location_o(upd_childs_location_o), .upd_childs_lr_o(upd_childs_lr_o),
    .fifo_level_o(fifo_level_o), .upd_idle_o(upd_idle_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pending updates, lookups issued since the queue
  // last drained or served, and edges elapsed since the last issued update.
  upd_t q[$];
  int   streak = 0;
  int   since_upd = 1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic upd_t rand_upd();
    upd_t u;
    u.ip   = $urandom;
    u.len  = 6'($urandom_range(0, 32));
    u.st   = SB'($urandom);
    u.loc  = LB'($urandom);
    u.cst  = SB'($urandom);
    u.cloc = LB'($urandom);
    u.lr   = 2'($urandom);
    return u;
  endfunction

  // One clock: check handshakes, predict the edge, then check the outputs.
  task automatic step();
    bit   e, lk_rdy_m, up_rdy_m, exp_lk, exp_up, exp_idle;
    logic [31:0] exp_ip;
    upd_t exp_u;
    #1;
    e = (q.size() != 0);
    if (!rst) begin
      lk_rdy_m = 1'b0;
      up_rdy_m = 1'b0;
    end else begin
      lk_rdy_m = !(e && streak == MAXR);
      up_rdy_m = (q.size() < DEPTH);
    end
    chk("lk_ready_o", lk_ready_o, lk_rdy_m);
    chk("upd_ready_o", upd_ready_o, up_rdy_m);
    exp_lk = 1'b0; exp_up = 1'b0; exp_ip = 32'h0; exp_u = '0;
    if (!rst) begin
      q.delete();
      streak = 0;
      since_upd = 1000;
    end else begin
      if (lk_valid && lk_rdy_m) begin
        exp_lk = 1'b1;
        exp_ip = lk_ip;
        streak = e ? ((streak < MAXR) ? streak + 1 : MAXR) : 0;
      end else if (e) begin
        exp_u  = q.pop_front();
        exp_up = 1'b1;
        exp_ip = exp_u.ip;
        streak = 0;
      end
      if (upd_valid && up_rdy_m) q.push_back(u_in);
      since_upd = exp_up ? 0 : ((since_upd < 1000) ? since_upd + 1 : 1000);
    end
    exp_idle = (q.size() == 0) && (since_upd >= NST + 2);
    @(posedge clk);
    #1;
    chk("lookup_o", lookup_o, exp_lk);
    chk("upd_o", upd_o, exp_up);
    chk("mutex", lookup_o & upd_o, 1'b0);
    chk("ip_addr_o", ip_addr_o, exp_ip);
    chk("upd_length_o", upd_length_o, exp_u.len);
    chk("upd_stage_id_o", upd_stage_id_o, exp_u.st);
    chk("upd_location_o", upd_location_o, exp_u.loc);
    chk("upd_childs_stage_id_o", upd_childs_stage_id_o, exp_u.cst);
    chk("upd_childs_location_o", upd_childs_location_o, exp_u.cloc);
    chk("upd_childs_lr_o", upd_childs_lr_o, exp_u.lr);
    chk("fifo_level_o", fifo_level_o, q.size());
    chk("upd_idle_o", upd_idle_o, exp_idle);
  endtask

  task automatic drive(input bit r, input bit lv, input logic [31:0] lip,
                       input bit uv, input upd_t u);
    rst = r; lk_valid = lv; lk_ip = lip; upd_valid = uv; u_in = u;
    step();
  endtask

  initial begin
    upd_t u;
    int hit;
    // Reset with requests presented: they must be dropped.
    u = rand_upd();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h1111_2222, 1'b1, u);

    // Idle single update, then drain past the in-flight window.
    u = '0;
    u.ip = 32'h0A00_0000; u.len = 6'd24; u.st = 6'd3; u.loc = 11'd5;
    drive(1'b1, 1'b0, 32'h0, 1'b1, u);
    for (int i = 0; i < NST + 6; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, '0);

    // Lookup priority: one update queued under a continuous lookup stream.
    drive(1'b1, 1'b1, 32'hC0A8_0001, 1'b1, rand_upd());
    for (int i = 0; i < 24; i++) drive(1'b1, 1'b1, 32'hC0A8_0001, 1'b0, '0);
    for (int i = 0; i < NST + 4; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, '0);

    // Full queue under saturated lookups, then steady push/pop across wraps.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, $urandom, 1'b1, rand_upd());
    chk("full_level", fifo_level_o, 8);
    chk("full_ready", upd_ready_o, 1'b0);
    for (int i = 0; i < 80; i++) drive(1'b1, 1'b1, $urandom, 1'b1, rand_upd());
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, '0);

    // Random traffic in three mixes.
    for (int i = 0; i < 9900; i++) begin
      int lp, up;
      lp = (i < 3300) ? 70 : ((i < 6600) ? 95 : 40);
      up = (i < 3300) ? 15 : ((i < 6600) ? 45 : 10);
      drive(1'b1, ($urandom_range(0, 99) < lp), $urandom,
            ($urandom_range(0, 99) < up), rand_upd());
    end
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, '0);

    // Reset mid-run: one update in flight and three queued.
    drive(1'b1, 1'b0, 32'h0, 1'b1, rand_upd());
    drive(1'b1, 1'b0, 32'h0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, $urandom, 1'b1, rand_upd());
    chk("pre_reset_level", fifo_level_o, 3);
    drive(1'b0, 1'b1, 32'h5, 1'b1, rand_upd());
    chk("post_reset_level", fifo_level_o, 0);
    chk("post_reset_idle", upd_idle_o, 1'b1);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, '0);
      if (upd_o) hit++;
    end
    chk("no_replay", hit, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbp_upd_sched.md
SBP_UPD_SCHED -- requirements
Module: sbp_upd_sched

Interface
Parameters:
REQ-001 SHALL have parameter STAGE_ID_BITS, default 6, meaning the width of the stage id field.
REQ-002 SHALL have parameter LOCATION_BITS, default 11, meaning the width of the entry location field.
REQ-003 SHALL have parameter NUM_STAGES, default 32, meaning the lookup pipeline depth, used to track updates in flight.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8 (power of 2, at least 2), meaning the number of update request entries.
REQ-005 SHALL have parameter MAX_LOOKUP_RUN, default 16 (at least 1), meaning the maximum number of consecutive lookups issued while an update is pending.
Ports:
REQ-006 SHALL have these ports; reset is synchronous and active-low:
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  reset, synchronous, active-low
- lk_valid_i  in  1  lookup request
- lk_ip_addr_i  in  32  lookup address
- lk_ready_o  out  1  lookup accepted this cycle when high together with lk_valid_i
- upd_valid_i  in  1  update request
- upd_ready_o  out  1  update accepted when high together with upd_valid_i
- upd_ip_addr_i  in  32  prefix
- upd_length_i  in  6  prefix length
- upd_stage_id_i  in  STAGE_ID_BITS  target stage
- upd_location_i  in  LOCATION_BITS  target location
- upd_childs_stage_id_i  in  STAGE_ID_BITS  child stage
- upd_childs_location_i  in  LOCATION_BITS  child location
- upd_childs_lr_i  in  2  child left/right flags
- lookup_o  out  1  lookup issued to the pipeline
- ip_addr_o  out  32  lookup address, or the update prefix when upd_o is high
- upd_o, upd_length_o, upd_stage_id_o, upd_location_o, upd_childs_stage_id_o, upd_childs_location_o, upd_childs_lr_o  out  (widths as the inputs)  update issued to the pipeline
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  number of queued updates
- upd_idle_o  out  1  FIFO empty and no update in flight

Function
REQ-007 SHALL register all pipeline-side outputs, so that a request accepted in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
REQ-008 SHALL never assert lookup_o and upd_o in the same cycle.
REQ-009 SHALL store accepted updates in a FIFO; upd_ready_o SHALL equal !full, be combinational, and not depend on upd_valid_i.
REQ-010 SHALL make a pushed entry eligible for issue no earlier than the cycle after the push; there is no bypass.
REQ-011 SHALL make the issue decision each cycle with the FIFO non-empty (E), lk_valid_i, and run counter RC:
- lk_ready_o = !(E and RC == MAX_LOOKUP_RUN).
- lk_valid_i and lk_ready_o: issue a lookup; RC increments (saturating at MAX_LOOKUP_RUN) if E, otherwise RC clears.
- Otherwise, if E: pop the head and issue an update; RC clears.
- Otherwise: issue nothing.
REQ-012 SHALL ensure that, while updates are pending under continuous lookups, the block issues at most MAX_LOOKUP_RUN lookups between consecutive updates.
REQ-013 SHALL drive ip_addr_o and the upd_* outputs to 0 when they are not carrying a valid issue.
REQ-014 SHALL allow a push and a pop in the same cycle; the level is then unchanged, pointers wrap modulo FIFO_DEPTH, and the FIFO order is preserved.
REQ-015 SHALL track updates in flight with a NUM_STAGES+1-bit shift register that is loaded with upd_o.
REQ-016 SHALL make upd_idle_o high only when the FIFO is empty, the shift register is all zero and upd_o is low.
REQ-017 SHALL make fifo_level_o reflect the level after the current clock edge, as a registered value.

Reset
REQ-018 SHALL, with rst low at a clock edge:
- empty the FIFO and clear RC and the shift register;
- drive lookup_o=0, upd_o=0, all data outputs 0, fifo_level_o=0 and upd_idle_o=1 from the next cycle.
REQ-019 SHALL drive lk_ready_o=0 and upd_ready_o=0 while rst is low; requests presented during reset are dropped.
REQ-020 SHALL discard queued and in-flight updates on a reset asserted mid-operation, and not replay them.

Verification
REQ-021 Idle single update: push stage=3, loc=5, len=24, ip=0x0A000000 with no lookups:
- upd_o high 2 cycles after the push edge, with matching fields;
- upd_idle_o returns high NUM_STAGES+1 cycles later.
REQ-022 Lookup priority: lk_valid_i held high with ip=0xC0A80001 and one update queued, MAX_LOOKUP_RUN=16:
- 16 lookups issue, then lk_ready_o is low for 1 cycle;
- upd_o fires in the next cycle and lookups resume.
REQ-023 Full FIFO: 8 pushes with lookups saturated:
- upd_ready_o low, fifo_level_o=8;
- a simultaneous pop and push keeps the level at 8 and the order is preserved across the pointer wrap.
REQ-024 Mutual exclusion: random lk_valid_i and upd_valid_i for 10k cycles:
- lookup_o and upd_o are never both high;
- the updates issued equal the pushes, in order;
- no lookup is lost when lk_ready_o was high.
REQ-025 Reset mid-run: assert rst low with 3 entries queued and 1 update in flight:
- next cycle fifo_level_o=0 and upd_idle_o=1;
- no upd_o pulse after reset.
